ulpi_bus_ctrl: RTL and testbench

Link-side ULPI bus controller between the USB core and the external ULPI PHY, clocked from the 60 MHz USB_CLKIN domain. It owns turnaround handling, RxCMD/receive capture and register read/write sequencing. It also arbitrates the bus between a register-access requester (PHY init/config logic) and a packet-transmit requester. The tri-state buffer lives in top; this block exposes split DATA_IN/DATA_OUT/DATA_OE.

---
 rtl/ulpi_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ulpi_bus_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_bus_ctrl.sv
// Link-side ULPI bus controller: turnaround, RxCMD/receive capture, register
// access sequencing and round-robin arbitration between register and packet requesters.
module ulpi_bus_ctrl #(
  parameter int unsigned NXT_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ULPI_DIR,
  input  logic       ULPI_NXT,
  input  logic [7:0] ULPI_DATA_IN,
  output logic [7:0] ULPI_DATA_OUT,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_STP,
  input  logic       REG_REQ,
  input  logic       REG_WE,
  input  logic [5:0] REG_ADDR,
  input  logic [7:0] REG_WDATA,
  output logic [7:0] REG_RDATA,
  output logic       REG_DONE,
  output logic       REG_ERR,
  input  logic       TX_REQ,
  input  logic [3:0] TX_PID,
  input  logic [7:0] TX_DATA,
  input  logic       TX_LAST,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ABORT,
  output logic       RX_ACTIVE,
  output logic       RX_VALID,
  output logic [7:0] RX_DATA,
  output logic [7:0] RXCMD,
  output logic       RXCMD_STB
);

  typedef enum logic [3:0] {
    S_IDLE, S_TURN_IN, S_RX, S_TURN_OUT, S_CMD, S_REG_WDATA, S_REG_STP,
    S_REG_RTURN, S_REG_RDATA, S_TX_DATA, S_TX_STP
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(NXT_TIMEOUT);

  state_t     state_q, state_d;
  logic       oe_q, oe_d;
  logic [7:0] data_out_q, data_out_d;
  logic       stp_q, stp_d;
  logic       last_tx_q, last_tx_d;   // 1 = packet path was granted most recently
  logic       op_tx_q, op_tx_d;
  logic       op_we_q, op_we_d;
  logic       err_q, err_d;
  logic       tx_last_q, tx_last_d;   // byte currently on the bus is the final one
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] reg_rdata_q, reg_rdata_d;
  logic       reg_done_q, reg_done_d;
  logic       reg_err_q, reg_err_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_abort_q, tx_abort_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] rxcmd_q, rxcmd_d;
  logic       rxcmd_stb_q, rxcmd_stb_d;

  logic       req_reg, req_tx, grant_reg, grant_tx;
  logic       link_drive, read_turn, dir_abort;
  logic       tx_ready;
  logic [7:0] cnt_inc;

  // A requester that just saw its DONE pulse still holds REQ for that cycle.
  assign req_reg   = REG_REQ & ~reg_done_q;
  assign req_tx    = TX_REQ & ~tx_done_q;
  assign grant_reg = req_reg & (~req_tx | last_tx_q);
  assign grant_tx  = req_tx & ~grant_reg;
  assign cnt_inc   = cnt_q + 8'd1;

  assign link_drive = (state_q == S_CMD) || (state_q == S_REG_WDATA) || (state_q == S_REG_STP) ||
                      (state_q == S_TX_DATA) || (state_q == S_TX_STP);
  // A read TXCMD accepted while the PHY already turns the bus is a normal read.
  assign read_turn  = (state_q == S_CMD) && !op_tx_q && !op_we_q && ULPI_NXT;
  assign dir_abort  = ULPI_DIR && link_drive && !read_turn;

  always_comb begin
    state_d     = state_q;
    oe_d        = oe_q;
    data_out_d  = data_out_q;
    stp_d       = stp_q;
    last_tx_d   = last_tx_q;
    op_tx_d     = op_tx_q;
    op_we_d     = op_we_q;
    err_d       = err_q;
    tx_last_d   = tx_last_q;
    cnt_d       = cnt_q;
    reg_rdata_d = reg_rdata_q;
    rx_data_d   = rx_data_q;
    rxcmd_d     = rxcmd_q;
    reg_done_d  = 1'b0;
    reg_err_d   = 1'b0;
    tx_done_d   = 1'b0;
    tx_abort_d  = 1'b0;
    rx_valid_d  = 1'b0;
    rxcmd_stb_d = 1'b0;
    tx_ready    = 1'b0;

    if (dir_abort) begin
      state_d    = S_TURN_IN;
      oe_d       = 1'b0;
      stp_d      = 1'b0;
      data_out_d = 8'h00;
      tx_done_d  = op_tx_q;
      tx_abort_d = op_tx_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ULPI_DIR) begin
            state_d = S_TURN_IN;
          end else if (grant_reg || grant_tx) begin
            state_d    = S_CMD;
            oe_d       = 1'b1;
            cnt_d      = 8'h00;
            err_d      = 1'b0;
            op_tx_d    = grant_tx;
            op_we_d    = REG_WE;
            last_tx_d  = grant_tx;
            data_out_d = grant_tx ? {4'h4, TX_PID} : {1'b1, ~REG_WE, REG_ADDR};
          end
        end
        S_TURN_IN: state_d = S_RX;
        S_RX: begin
          if (!ULPI_DIR) begin
            state_d = S_TURN_OUT;
          end else if (ULPI_NXT) begin
            rx_data_d  = ULPI_DATA_IN;
            rx_valid_d = 1'b1;
          end else begin
            rxcmd_d     = ULPI_DATA_IN;
            rxcmd_stb_d = 1'b1;
          end
        end
        S_TURN_OUT: state_d = S_IDLE;
        S_CMD, S_REG_WDATA: begin
          if (ULPI_NXT) begin
            if (state_q == S_REG_WDATA) begin
              state_d    = S_REG_STP;
              stp_d      = 1'b1;
              data_out_d = 8'h00;
            end else if (op_tx_q) begin
              state_d    = S_TX_DATA;
              data_out_d = TX_DATA;
              tx_last_d  = TX_LAST;
              tx_ready   = 1'b1;
            end else if (op_we_q) begin
              state_d    = S_REG_WDATA;
              data_out_d = REG_WDATA;
            end else begin
              state_d    = ULPI_DIR ? S_REG_RDATA : S_REG_RTURN;
              oe_d       = 1'b0;
              data_out_d = 8'h00;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              state_d    = op_tx_q ? S_TX_STP : S_REG_STP;
              stp_d      = 1'b1;
              data_out_d = 8'h00;
              err_d      = 1'b1;
            end
          end
        end
        S_REG_STP: begin
          state_d    = S_IDLE;
          stp_d      = 1'b0;
          oe_d       = 1'b0;
          reg_done_d = 1'b1;
          reg_err_d  = err_q;
        end
        S_REG_RTURN: if (ULPI_DIR) state_d = S_REG_RDATA;
        S_REG_RDATA: begin
          reg_rdata_d = ULPI_DATA_IN;
          reg_done_d  = 1'b1;
          state_d     = S_TURN_OUT;
        end
        S_TX_DATA: begin
          if (ULPI_NXT) begin
            if (tx_last_q) begin
              state_d    = S_TX_STP;
              stp_d      = 1'b1;
              data_out_d = 8'h00;
            end else begin
              data_out_d = TX_DATA;
              tx_last_d  = TX_LAST;
              tx_ready   = 1'b1;
            end
          end
        end
        S_TX_STP: begin
          state_d    = S_IDLE;
          stp_d      = 1'b0;
          oe_d       = 1'b0;
          tx_done_d  = 1'b1;
          tx_abort_d = err_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      oe_q        <= 1'b0;
      data_out_q  <= 8'h00;
      stp_q       <= 1'b0;
      last_tx_q   <= 1'b1;
      op_tx_q     <= 1'b0;
      op_we_q     <= 1'b0;
      err_q       <= 1'b0;
      tx_last_q   <= 1'b0;
      cnt_q       <= 8'h00;
      reg_rdata_q <= 8'h00;
      reg_done_q  <= 1'b0;
      reg_err_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_abort_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rxcmd_q     <= 8'h00;
      rxcmd_stb_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      oe_q        <= oe_d;
      data_out_q  <= data_out_d;
      stp_q       <= stp_d;
      last_tx_q   <= last_tx_d;
      op_tx_q     <= op_tx_d;
      op_we_q     <= op_we_d;
      err_q       <= err_d;
      tx_last_q   <= tx_last_d;
      cnt_q       <= cnt_d;
      reg_rdata_q <= reg_rdata_d;
      reg_done_q  <= reg_done_d;
      reg_err_q   <= reg_err_d;
      tx_done_q   <= tx_done_d;
      tx_abort_q  <= tx_abort_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rxcmd_q     <= rxcmd_d;
      rxcmd_stb_q <= rxcmd_stb_d;
    end
  end

  assign ULPI_DATA_OUT = data_out_q;
  assign ULPI_DATA_OE  = oe_q & ~ULPI_DIR;
  assign ULPI_STP      = stp_q;
  assign REG_RDATA     = reg_rdata_q;
  assign REG_DONE      = reg_done_q;
  assign REG_ERR       = reg_err_q;
  assign TX_READY      = tx_ready;
  assign TX_DONE       = tx_done_q;
  assign TX_ABORT      = tx_abort_q;
  assign RX_ACTIVE     = (state_q == S_RX);
  assign RX_VALID      = rx_valid_q;
  assign RX_DATA       = rx_data_q;
  assign RXCMD         = rxcmd_q;
  assign RXCMD_STB     = rxcmd_stb_q;

endmodule

// File: tb/tb_ulpi_bus_ctrl.sv
// Bench for ulpi_bus_ctrl: a small PHY/requester emulator drives register and
// packet transactions; expectations come from tables and a transaction-level model.
module tb_ulpi_bus_ctrl;
  localparam int TO = 4;

  logic       CLK = 0;
  logic       RST;
  logic       ULPI_DIR, ULPI_NXT;
  logic [7:0] ULPI_DATA_IN, ULPI_DATA_OUT;
  logic       ULPI_DATA_OE, ULPI_STP;
  logic       REG_REQ, REG_WE;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_WDATA, REG_RDATA;
  logic       REG_DONE, REG_ERR;
  logic       TX_REQ;
  logic [3:0] TX_PID;
  logic [7:0] TX_DATA;
  logic       TX_LAST, TX_READY, TX_DONE, TX_ABORT;
  logic       RX_ACTIVE, RX_VALID;
  logic [7:0] RX_DATA, RXCMD;
  logic       RXCMD_STB;

  ulpi_bus_ctrl #(.NXT_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .ULPI_DIR(ULPI_DIR), .ULPI_NXT(ULPI_NXT),
    .ULPI_DATA_IN(ULPI_DATA_IN), .ULPI_DATA_OUT(ULPI_DATA_OUT), .ULPI_DATA_OE(ULPI_DATA_OE),
    .ULPI_STP(ULPI_STP), .REG_REQ(REG_REQ), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
    .REG_WDATA(REG_WDATA), .REG_RDATA(REG_RDATA), .REG_DONE(REG_DONE), .REG_ERR(REG_ERR),
    .TX_REQ(TX_REQ), .TX_PID(TX_PID), .TX_DATA(TX_DATA), .TX_LAST(TX_LAST),
    .TX_READY(TX_READY), .TX_DONE(TX_DONE), .TX_ABORT(TX_ABORT), .RX_ACTIVE(RX_ACTIVE),
    .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RXCMD(RXCMD), .RXCMD_STB(RXCMD_STB)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  int reg_done_cnt = 0;
  logic [7:0] tx_bytes [8];

  always @(negedge CLK) if (REG_DONE === 1'b1) reg_done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    ULPI_DIR = 0; ULPI_NXT = 0; ULPI_DATA_IN = 0;
    repeat (n) step();
  endtask

  // PHY side of one register access; delay = NXT-low cycles before accepting the TXCMD.
  task automatic reg_op(input logic we, input logic [5:0] addr, input logic [7:0] wdata,
                        input logic [7:0] phy, input int delay, input logic early,
                        output logic [7:0] cmd_seen, output logic [7:0] data_seen,
                        output logic err, output int stp_n, output logic done,
                        output logic clash);
    int ph, waited;
    cmd_seen = 0; data_seen = 0; err = 0; stp_n = 0; done = 0; clash = 0;
    ph = 0; waited = 0;
    REG_REQ = 1; REG_WE = we; REG_ADDR = addr; REG_WDATA = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      step();
      ULPI_NXT = 0; ULPI_DIR = 0; ULPI_DATA_IN = 8'h00;
      if (ULPI_STP) begin
        stp_n++;
        if (ULPI_DATA_OUT !== 8'h00) clash = 1;
      end
      if (REG_DONE) begin
        done = 1; err = REG_ERR; REG_REQ = 0;
        if (!we) data_seen = REG_RDATA;
      end
      case (ph)
        0: if (ULPI_DATA_OE) begin cmd_seen = ULPI_DATA_OUT; ph = 1; end
        2: begin data_seen = ULPI_DATA_OUT; ULPI_NXT = 1; ph = 4; end
        3: begin ULPI_DIR = 1; ph = 5; end
        5: begin ULPI_DIR = 1; ULPI_DATA_IN = phy; ph = 6; end
        default: ;
      endcase
      if (ph == 1 && !ULPI_STP && !done) begin
        if (waited < delay) waited++;
        else begin
          ULPI_NXT = 1;
          if (we) ph = 2;
          else if (early) begin ULPI_DIR = 1; ph = 5; end
          else ph = 3;
        end
      end
      #1;
      if (ULPI_DIR && ULPI_DATA_OE) clash = 1;
    end
    REG_REQ = 0;
    $display("txn reg we=%0d addr=%02h cmd=%02h data=%02h err=%0d stp=%0d done=%0d",
             we, addr, cmd_seen, data_seen, err, stp_n, done);
  endtask

  // PHY + packet requester; abort_at = accepted-byte count at which PHY grabs the bus (-1: never).
  task automatic tx_op(input logic [3:0] pid, input int n, input int delay, input int abort_at,
                       output logic [7:0] cmd_seen, output int ready_n, output int stp_n,
                       output logic done, output logic abort, output logic bytes_ok);
    int ph, waited, idx, acc;
    cmd_seen = 0; ready_n = 0; stp_n = 0; done = 0; abort = 0; bytes_ok = 1;
    ph = 0; waited = 0; idx = 0; acc = 0;
    TX_REQ = 1; TX_PID = pid;
    TX_DATA = tx_bytes[0]; TX_LAST = (n == 1);
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      step();
      ULPI_NXT = 0; ULPI_DIR = 0; ULPI_DATA_IN = 8'h00;
      TX_DATA = (idx < n) ? tx_bytes[idx] : 8'h00;
      TX_LAST = (idx == n - 1);
      if (ULPI_STP) begin stp_n++; ph = 3; end
      if (TX_DONE) begin done = 1; abort = TX_ABORT; TX_REQ = 0; end
      else if (ph == 0 && ULPI_DATA_OE) begin cmd_seen = ULPI_DATA_OUT; ph = 1; end
      if (ph == 1 && !done) begin
        if (waited < delay) waited++;
        else begin ULPI_NXT = 1; ph = 2; end
      end else if (ph == 2 && !done) begin
        if (acc == abort_at) begin ULPI_DIR = 1; ph = 3; end
        else if ($urandom_range(0, 2) != 0) begin
          ULPI_NXT = 1;
          if (acc >= n || ULPI_DATA_OUT !== tx_bytes[acc]) bytes_ok = 0;
          acc++;
        end
      end
      #1;
      if (TX_READY) begin ready_n++; idx++; end
    end
    TX_REQ = 0;
    if (abort_at < 0 && delay < TO && acc != n) bytes_ok = 0;
    $display("txn tx pid=%0h len=%0d cmd=%02h ready=%0d stp=%0d done=%0d abort=%0d",
             pid, n, cmd_seen, ready_n, stp_n, done, abort);
  endtask

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] phy;
    int         delay;
    logic       early;
    logic [7:0] exp_cmd;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_stp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0] c, d;
    logic e, dn, cl, ab, ok;
    int s, r, cnt0;

    vecs[0] = '{1'b1, 6'h04, 8'h45, 8'h00, 1, 1'b0, 8'h84, 8'h45, 1'b0, 1};
    vecs[1] = '{1'b0, 6'h0A, 8'h00, 8'h5A, 0, 1'b0, 8'hCA, 8'h5A, 1'b0, 0};
    vecs[2] = '{1'b0, 6'h00, 8'h00, 8'hA5, 3, 1'b0, 8'hC0, 8'hA5, 1'b0, 0};
    vecs[3] = '{1'b0, 6'h2B, 8'h00, 8'h3E, 1, 1'b1, 8'hEB, 8'h3E, 1'b0, 0};
    vecs[4] = '{1'b1, 6'h3F, 8'h12, 8'h00, 9, 1'b0, 8'hBF, 8'h00, 1'b1, 1};
    vecs[5] = '{1'b0, 6'h15, 8'h00, 8'h77, 4, 1'b0, 8'hD5, 8'h00, 1'b1, 1};

    RST = 1; ULPI_DIR = 0; ULPI_NXT = 0; ULPI_DATA_IN = 0;
    REG_REQ = 0; REG_WE = 0; REG_ADDR = 0; REG_WDATA = 0;
    TX_REQ = 0; TX_PID = 0; TX_DATA = 0; TX_LAST = 0;
    repeat (3) step();
    check("rst_oe", ULPI_DATA_OE, 0);
    check("rst_dout", ULPI_DATA_OUT, 0);
    check("rst_stp", ULPI_STP, 0);
    check("rst_flags", {REG_DONE, REG_ERR, TX_READY, TX_DONE, TX_ABORT, RX_ACTIVE, RX_VALID, RXCMD_STB}, 0);
    check("rst_rxcmd", RXCMD, 8'h00);
    RST = 0;
    idle(2);

    // First contention: REG wins, TX follows.
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
    TX_REQ = 1; TX_PID = 4'h3; TX_DATA = 8'h11; TX_LAST = 0;
    reg_op(1'b1, 6'h01, 8'h99, 8'h00, 0, 1'b0, c, d, e, s, dn, cl);
    check("arb1_reg_cmd", c, 8'h81);
    check("arb1_reg_done", dn, 1);
    tx_op(4'h3, 3, 1, -1, c, r, s, dn, ab, ok);
    check("arb1_tx_cmd", c, 8'h43);
    check("arb1_tx_ready", r, 3);
    check("arb1_tx_stp", s, 1);
    check("arb1_tx_bytes", ok, 1);
    check("arb1_tx_abort", {dn, ab}, 2'b10);
    idle(2);
    // Second contention: TX was last, so REG wins again.
    TX_REQ = 1; TX_PID = 4'h3; TX_DATA = 8'h11; TX_LAST = 0;
    reg_op(1'b0, 6'h02, 8'h00, 8'h6B, 0, 1'b0, c, d, e, s, dn, cl);
    check("arb2_reg_cmd", c, 8'hC2);
    check("arb2_reg_rdata", d, 8'h6B);
    tx_op(4'h3, 3, 0, -1, c, r, s, dn, ab, ok);
    check("arb2_tx_cmd", c, 8'h43);
    idle(2);
    // REG alone, then contention: TX must now win.
    reg_op(1'b1, 6'h05, 8'h01, 8'h00, 0, 1'b0, c, d, e, s, dn, cl);
    idle(2);
    REG_REQ = 1; REG_WE = 1; REG_ADDR = 6'h06; REG_WDATA = 8'h66;
    tx_op(4'h9, 2, 0, -1, c, r, s, dn, ab, ok);
    check("arb3_tx_first", c, 8'h49);
    reg_op(1'b1, 6'h06, 8'h66, 8'h00, 0, 1'b0, c, d, e, s, dn, cl);
    check("arb3_reg_second", c, 8'h86);
    idle(2);

    // Table-driven register accesses.
    for (int i = 0; i < 6; i++) begin
      reg_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].phy, vecs[i].delay,
             vecs[i].early, c, d, e, s, dn, cl);
      check($sformatf("vec%0d_cmd", i), c, vecs[i].exp_cmd);
      check($sformatf("vec%0d_done", i), dn, 1);
      check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      check($sformatf("vec%0d_stp", i), s, vecs[i].exp_stp);
      check($sformatf("vec%0d_clash", i), cl, 0);
      if (!vecs[i].exp_err) check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      idle(2);
    end

    // RxCMD then receive data.
    ULPI_DIR = 1; step();
    ULPI_DATA_IN = 8'hFF; step();
    check("rx_active_entry", RX_ACTIVE, 1);
    check("rx_turn_ignored", RXCMD_STB, 0);
    ULPI_DATA_IN = 8'h01; ULPI_NXT = 0; step();
    check("rxcmd_stb", RXCMD_STB, 1);
    check("rxcmd_val", RXCMD, 8'h01);
    ULPI_DATA_IN = 8'h3C; ULPI_NXT = 1; step();
    check("rx_valid", {RX_VALID, RX_DATA}, {1'b1, 8'h3C});
    check("rx_active_mid", RX_ACTIVE, 1);
    ULPI_DIR = 0; ULPI_NXT = 0; step();
    check("rx_active_turnout", RX_ACTIVE, 0);
    idle(2);

    // PHY takes the bus during a register write TXCMD.
    cnt0 = reg_done_cnt;
    REG_REQ = 1; REG_WE = 1; REG_ADDR = 6'h04; REG_WDATA = 8'h45;
    step();
    check("abort_cmd_oe", ULPI_DATA_OE, 1);
    ULPI_DIR = 1; ULPI_NXT = 0; #1;
    check("abort_oe_same_cycle", ULPI_DATA_OE, 0);
    step();
    step();
    ULPI_DATA_IN = 8'h2E; step();
    check("abort_rxcmd", {RXCMD_STB, RXCMD}, {1'b1, 8'h2E});
    ULPI_DIR = 0; ULPI_DATA_IN = 0; step();
    reg_op(1'b1, 6'h04, 8'h45, 8'h00, 0, 1'b0, c, d, e, s, dn, cl);
    check("abort_reissue_cmd", c, 8'h84);
    check("abort_reissue_data", d, 8'h45);
    idle(3);
    check("abort_done_once", reg_done_cnt - cnt0, 1);

    // PHY takes the bus mid-packet.
    tx_bytes[0] = 8'hA0; tx_bytes[1] = 8'hA1; tx_bytes[2] = 8'hA2; tx_bytes[3] = 8'hA3;
    tx_op(4'h5, 4, 0, 2, c, r, s, dn, ab, ok);
    check("txabort_done", {dn, ab}, 2'b11);
    check("txabort_ready", r, 3);
    check("txabort_stp", s, 0);
    idle(4);

    // Reset in the middle of a register access.
    cnt0 = reg_done_cnt;
    REG_REQ = 1; REG_WE = 1; REG_ADDR = 6'h07; REG_WDATA = 8'h70;
    step();
    check("rst_mid_pre_oe", ULPI_DATA_OE, 1);
    RST = 1; REG_REQ = 0; step();
    check("rst_mid_oe", {ULPI_DATA_OE, ULPI_STP}, 0);
    RST = 0; idle(4);
    check("rst_mid_no_done", reg_done_cnt - cnt0, 0);

    // Randomized traffic against the transaction model.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic we, early, exp_err;
        logic [5:0] addr;
        logic [7:0] wd, phy;
        int dly;
        we = 1'($urandom_range(0, 1)); addr = 6'($urandom); wd = 8'($urandom);
        phy = 8'($urandom); dly = $urandom_range(0, 5);
        early = !we && ($urandom_range(0, 3) == 0);
        exp_err = (dly >= TO);
        reg_op(we, addr, wd, phy, dly, early, c, d, e, s, dn, cl);
        check("rnd_reg_cmd", c, we ? (8'h80 | 8'(addr)) : (8'hC0 | 8'(addr)));
        check("rnd_reg_done_err", {dn, e}, {1'b1, exp_err});
        check("rnd_reg_stp", s, (we || exp_err) ? 1 : 0);
        check("rnd_reg_clash", cl, 0);
        if (!exp_err) check("rnd_reg_data", d, we ? wd : phy);
      end else begin
        logic [3:0] pid;
        int n, dly;
        logic exp_ab;
        pid = 4'($urandom); n = $urandom_range(1, 4); dly = $urandom_range(0, 5);
        for (int k = 0; k < n; k++) tx_bytes[k] = 8'($urandom);
        exp_ab = (dly >= TO);
        tx_op(pid, n, dly, -1, c, r, s, dn, ab, ok);
        check("rnd_tx_cmd", c, 8'h40 | 8'(pid));
        check("rnd_tx_done_abort", {dn, ab}, {1'b1, exp_ab});
        check("rnd_tx_ready", r, exp_ab ? 0 : n);
        check("rnd_tx_stp", s, 1);
        if (!exp_ab) check("rnd_tx_bytes", ok, 1);
      end
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
